// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone RAM slave and its storage array.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2
    } wbState_e;

    function automatic int selWidth(input int dataWidth);
        return dataWidth / 8;
    endfunction

    // Number of low address bits that select a byte inside one data word.
    function automatic int byteShift(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/wb_ram_slave_mem.sv
// Storage array: synchronous byte-enabled write, one combinational read port, no reset.
module wb_ram_slave_mem
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                            i_clk,
    input  logic                            i_we,
    input  logic [IDX_WIDTH-1:0]            i_idx,
    input  logic [selWidth(DATA_WIDTH)-1:0] i_sel,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    output logic [DATA_WIDTH-1:0]           o_rdata
);

    localparam int SEL_W = selWidth(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (i_sel[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave fronting a byte-enabled RAM with a fixed number of wait states.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [ADDR_WIDTH-1:0]           adr_i,
    input  logic [DATA_WIDTH-1:0]           dat_i,
    output logic [DATA_WIDTH-1:0]           dat_o,
    input  logic                            we_i,
    input  logic [selWidth(DATA_WIDTH)-1:0] sel_i,
    input  logic                            stb_i,
    input  logic                            cyc_i,
    output logic                            ack_o,
    output logic                            err_o
);

    localparam int                    SEL_W    = selWidth(DATA_WIDTH);
    localparam int                    SHIFT    = byteShift(DATA_WIDTH);
    localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [3:0]            CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit                    NO_WAIT  = (WAIT_STATES == 0);

    wbState_e              r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_idle;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_adr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_we;
    logic [SEL_W-1:0]      w_sel;
    logic [ADDR_WIDTH:0]   w_diff;
    logic [ADDR_WIDTH-1:0] w_wordIdx;
    logic                  w_inRange;
    logic                  w_goTerm;
    logic                  w_memWe;
    logic [DATA_WIDTH-1:0] w_memRdata;
    logic [DATA_WIDTH-1:0] w_termData;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && cyc_i && stb_i;

    // In IDLE the live bus drives decode so a zero-wait transfer can finish on its accept edge.
    assign w_adr   = w_idle ? adr_i : r_adr;
    assign w_wdata = w_idle ? dat_i : r_wdata;
    assign w_we    = w_idle ? we_i  : r_we;
    assign w_sel   = w_idle ? sel_i : r_sel;

    // The extra borrow bit flags addresses below the base instead of letting them wrap.
    assign w_diff     = {1'b0, w_adr} - BASE_EXT;
    assign w_wordIdx  = w_diff[ADDR_WIDTH-1:0] >> SHIFT;
    assign w_inRange  = !w_diff[ADDR_WIDTH] && (w_wordIdx < DEPTH_A);

    assign w_goTerm   = (w_accept && NO_WAIT) || ((r_state == WAIT) && cyc_i && (r_cnt == 4'd0));
    assign w_memWe    = !rst_i && w_goTerm && w_we && w_inRange;
    assign w_termData = (w_inRange && !w_we) ? w_memRdata : '0;

    wb_ram_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_W)
    ) u_mem (
        .i_clk   (clk_i),
        .i_we    (w_memWe),
        .i_idx   (w_wordIdx[IDX_W-1:0]),
        .i_sel   (w_sel),
        .i_wdata (w_wdata),
        .o_rdata (w_memRdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    if (w_accept) begin
                        r_adr   <= adr_i;
                        r_wdata <= dat_i;
                        r_we    <= we_i;
                        r_sel   <= sel_i;
                        if (NO_WAIT) begin
                            r_state <= TERM;
                            r_ack   <= w_inRange;
                            r_err   <= !w_inRange;
                            r_rdata <= w_termData;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!cyc_i) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= TERM;
                        r_ack   <= w_inRange;
                        r_err   <= !w_inRange;
                        r_rdata <= w_termData;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                TERM: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    assign ack_o = r_ack;
    assign err_o = r_err;
    assign dat_o = r_rdata;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: three instances cover one, three and zero wait states.
module tb_wb_ram_slave;

    localparam int          NDUT = 3;
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        int          dut;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        bit          chkDat;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst  [NDUT];
    logic [31:0] adr  [NDUT];
    logic [31:0] datI [NDUT];
    logic [31:0] datO [NDUT];
    logic        weI  [NDUT];
    logic [3:0]  sel  [NDUT];
    logic        stb  [NDUT];
    logic        cyc  [NDUT];
    logic        ack  [NDUT];
    logic        err  [NDUT];

    int          checks = 0;
    int          errors = 0;
    exp_t        expQ [$];
    logic [31:0] model [NDUT][256];
    bit          known [NDUT][256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int WSG = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        wb_ram_slave #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .DEPTH       (256),
            .BASE_ADDR   (32'h0000_1000),
            .WAIT_STATES (WSG)
        ) uDut (
            .clk_i (clk),
            .rst_i (rst[g]),
            .adr_i (adr[g]),
            .dat_i (datI[g]),
            .dat_o (datO[g]),
            .we_i  (weI[g]),
            .sel_i (sel[g]),
            .stb_i (stb[g]),
            .cyc_i (cyc[g]),
            .ack_o (ack[g]),
            .err_o (err[g])
        );
    end

    function automatic int wsOf(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    // Predicts the termination of one transfer and updates the reference memory.
    task automatic pushExpected(input int d, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] s);
        exp_t e;
        int   idx;
        bit   inR;
        inR      = (a >= BASE) && (((a - BASE) >> 2) < 32'd256);
        e.dut    = d;
        e.ack    = inR;
        e.err    = !inR;
        e.lat    = wsOf(d) + 1;
        e.dat    = 32'h0;
        e.chkDat = !we;
        if (inR) begin
            idx = int'((a - BASE) >> 2);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
                end
                if (s == 4'hF) known[d][idx] = 1'b1;
            end else begin
                e.dat    = model[d][idx];
                e.chkDat = known[d][idx];
            end
        end
        expQ.push_back(e);
    endtask

    // Runs one single transfer and reports what terminated it and when.
    task automatic applyStimulus(input int d, input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] s,
                                 output logic oAck, output logic oErr,
                                 output logic [31:0] oDat, output int oLat);
        @(negedge clk);
        cyc[d]  = 1'b1;
        stb[d]  = 1'b1;
        weI[d]  = we;
        adr[d]  = a;
        datI[d] = wd;
        sel[d]  = s;
        @(posedge clk);
        oAck = 1'b0;
        oErr = 1'b0;
        oDat = 32'h0;
        oLat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ack[d] === 1'b1 || err[d] === 1'b1) begin
                oAck = ack[d];
                oErr = err[d];
                oDat = datO[d];
                oLat = c;
                break;
            end
        end
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
        weI[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || datO[d] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: ack/err/dat got %b/%b/%h expected 0/0/00000000",
                         d, ack[d], err[d], datO[d]);
            end
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] tAdr [4] = '{32'h1004, 32'h1004, 32'h1004, 32'h1004};
        logic        tWe  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] tDat [4] = '{32'hDEADBEEF, 32'h0, 32'h000000AA, 32'h0};
        logic [3:0]  tSel [4] = '{4'hF, 4'h0, 4'h1, 4'h0};
        logic        oAck, oErr;
        logic [31:0] oDat;
        int          oLat;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            pushExpected(0, tWe[i], tAdr[i], tDat[i], tSel[i]);
            applyStimulus(0, tWe[i], tAdr[i], tDat[i], tSel[i], oAck, oErr, oDat, oLat);
            e = expQ.pop_front();
            checks++;
            if (oAck !== e.ack || oErr !== e.err) begin
                errors++;
                $display("[TB] FAIL wr_rd op%0d ack/err: got %b/%b expected %b/%b", i, oAck, oErr, e.ack, e.err);
            end
            checks++;
            if (oLat !== e.lat) begin
                errors++;
                $display("[TB] FAIL wr_rd op%0d latency: got %0d expected %0d", i, oLat, e.lat);
            end
            if (e.chkDat) begin
                checks++;
                if (oDat !== e.dat) begin
                    errors++;
                    $display("[TB] FAIL wr_rd op%0d data: got %h expected %h", i, oDat, e.dat);
                end
            end
        end
        checks++;
        if (oDat !== 32'hDEADBEAA) begin
            errors++;
            $display("[TB] FAIL wr_rd merged word: got %h expected deadbeaa", oDat);
        end
    endtask

    task automatic test_range();
        logic [31:0] tAdr [11] = '{32'h1000, 32'h1400, 32'h0FFC, 32'h13FC, 32'hFFFFFFFC, 32'h1400,
                                   32'h1000, 32'h1010, 32'h1010, 32'h1010, 32'h1006};
        logic        tWe  [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] tDat [11] = '{32'h01020304, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5A5A5A5A,
                                   32'h0, 32'h0BADCAFE, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [3:0]  tSel [11] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h2};
        logic        oAck, oErr;
        logic [31:0] oDat;
        int          oLat;
        exp_t        e;
        for (int i = 0; i < 11; i++) begin
            pushExpected(0, tWe[i], tAdr[i], tDat[i], tSel[i]);
            applyStimulus(0, tWe[i], tAdr[i], tDat[i], tSel[i], oAck, oErr, oDat, oLat);
            e = expQ.pop_front();
            checks++;
            if (oAck !== e.ack || oErr !== e.err) begin
                errors++;
                $display("[TB] FAIL range op%0d adr %h ack/err: got %b/%b expected %b/%b",
                         i, tAdr[i], oAck, oErr, e.ack, e.err);
            end
            checks++;
            if (oLat !== e.lat) begin
                errors++;
                $display("[TB] FAIL range op%0d latency: got %0d expected %0d", i, oLat, e.lat);
            end
            if (e.chkDat) begin
                checks++;
                if (oDat !== e.dat) begin
                    errors++;
                    $display("[TB] FAIL range op%0d data: got %h expected %h", i, oDat, e.dat);
                end
            end
        end
    endtask

    task automatic test_cancel();
        logic        oAck, oErr;
        logic [31:0] oDat;
        int          oLat;
        exp_t        e;
        bit          sawTerm;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                pushExpected(1, 1'b1, 32'h1008, 32'hCAFEF00D, 4'hF);
                applyStimulus(1, 1'b1, 32'h1008, 32'hCAFEF00D, 4'hF, oAck, oErr, oDat, oLat);
            end else begin
                // Abandon a write in its second wait cycle before reading the word back.
                sawTerm = 1'b0;
                @(negedge clk);
                cyc[1] = 1'b1; stb[1] = 1'b1; weI[1] = 1'b1;
                adr[1] = 32'h1008; datI[1] = 32'h12345678; sel[1] = 4'hF;
                @(posedge clk);
                @(negedge clk);
                if (ack[1] !== 1'b0 || err[1] !== 1'b0) sawTerm = 1'b1;
                @(posedge clk);
                @(negedge clk);
                cyc[1] = 1'b0; stb[1] = 1'b0; weI[1] = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    if (ack[1] !== 1'b0 || err[1] !== 1'b0) sawTerm = 1'b1;
                end
                checks++;
                if (sawTerm !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cancel termination: got 1 expected 0");
                end
                pushExpected(1, 1'b0, 32'h1008, 32'h0, 4'hF);
                applyStimulus(1, 1'b0, 32'h1008, 32'h0, 4'hF, oAck, oErr, oDat, oLat);
            end
            e = expQ.pop_front();
            checks++;
            if (oAck !== e.ack || oErr !== e.err || oLat !== e.lat) begin
                errors++;
                $display("[TB] FAIL cancel op%0d ack/err/lat: got %b/%b/%0d expected %b/%b/%0d",
                         i, oAck, oErr, oLat, e.ack, e.err, e.lat);
            end
            if (e.chkDat) begin
                checks++;
                if (oDat !== e.dat) begin
                    errors++;
                    $display("[TB] FAIL cancel readback: got %h expected %h", oDat, e.dat);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        oAck, oErr;
        logic [31:0] oDat;
        int          oLat;
        exp_t        e;
        bit          expAck;
        pushExpected(2, 1'b1, 32'h1020, 32'h0A0B0C0D, 4'hF);
        applyStimulus(2, 1'b1, 32'h1020, 32'h0A0B0C0D, 4'hF, oAck, oErr, oDat, oLat);
        e = expQ.pop_front();
        checks++;
        if (oAck !== e.ack || oLat !== e.lat) begin
            errors++;
            $display("[TB] FAIL b2b write ack/lat: got %b/%0d expected %b/%0d", oAck, oLat, e.ack, e.lat);
        end
        for (int i = 0; i < 3; i++) pushExpected(2, 1'b0, 32'h1020, 32'h0, 4'h0);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; weI[2] = 1'b0; adr[2] = 32'h1020; sel[2] = 4'h0;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            expAck = (k % 2 == 1);
            checks++;
            if (ack[2] !== expAck) begin
                errors++;
                $display("[TB] FAIL b2b cycle%0d ack: got %b expected %b", k, ack[2], expAck);
            end
            if (ack[2] === 1'b1 && expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if (datO[2] !== e.dat) begin
                    errors++;
                    $display("[TB] FAIL b2b cycle%0d data: got %h expected %h", k, datO[2], e.dat);
                end
            end
        end
        cyc[2] = 1'b0; stb[2] = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b unterminated reads: got %0d expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset_midway();
        logic        oAck, oErr;
        logic [31:0] oDat;
        int          oLat;
        exp_t        e;
        pushExpected(0, 1'b1, 32'h100C, 32'h11223344, 4'hF);
        applyStimulus(0, 1'b1, 32'h100C, 32'h11223344, 4'hF, oAck, oErr, oDat, oLat);
        e = expQ.pop_front();
        checks++;
        if (oAck !== e.ack || oLat !== e.lat) begin
            errors++;
            $display("[TB] FAIL rst_mid setup ack/lat: got %b/%0d expected %b/%0d", oAck, oLat, e.ack, e.lat);
        end
        // Reset landing in the TERM cycle of a read must clear the outputs at once.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; weI[0] = 1'b0; adr[0] = 32'h1004; sel[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ack[0] !== 1'b1 || datO[0] !== 32'hDEADBEAA) begin
            errors++;
            $display("[TB] FAIL rst_mid term before reset: ack/dat got %b/%h expected 1/deadbeaa", ack[0], datO[0]);
        end
        #1 rst[0] = 1'b1;
        #1;
        checks++;
        if (ack[0] !== 1'b0 || err[0] !== 1'b0 || datO[0] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid term async clear: ack/err/dat got %b/%b/%h expected 0/0/0",
                     ack[0], err[0], datO[0]);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        // Reset while a write sits in WAIT, held across the edge that would commit it.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; weI[0] = 1'b1;
        adr[0] = 32'h100C; datI[0] = 32'h55667788; sel[0] = 4'hF;
        @(posedge clk);
        #2 rst[0] = 1'b1;
        #1;
        checks++;
        if (ack[0] !== 1'b0 || err[0] !== 1'b0 || datO[0] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid wait async clear: ack/err/dat got %b/%b/%h expected 0/0/0",
                     ack[0], err[0], datO[0]);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0; weI[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        pushExpected(0, 1'b0, 32'h100C, 32'h0, 4'hF);
        applyStimulus(0, 1'b0, 32'h100C, 32'h0, 4'hF, oAck, oErr, oDat, oLat);
        e = expQ.pop_front();
        checks++;
        if (oAck !== e.ack || oDat !== e.dat) begin
            errors++;
            $display("[TB] FAIL rst_mid readback ack/dat: got %b/%h expected %b/%h", oAck, oDat, e.ack, e.dat);
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d]  = 1'b0;
            adr[d]  = 32'h0;
            datI[d] = 32'h0;
            weI[d]  = 1'b0;
            sel[d]  = 4'h0;
            stb[d]  = 1'b0;
            cyc[d]  = 1'b0;
        end
        test_reset();
        test_write_read();
        test_range();
        test_cancel();
        test_back_to_back();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
